// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings and widths for the instruction fetch unit and its pc_next helper.
package instr_fetch_unit_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_BR   = 2'b10;
   localparam logic [1:0] PS_JR   = 2'b11;

   typedef enum logic [1:0] {
      FSM_FETCH = 2'b00,
      FSM_EXEC  = 2'b01,
      FSM_HALT  = 2'b10
   } fsm_e;

   // Instruction word field positions
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int DR_MSB  = 11;
   localparam int DR_LSB  = 8;
   localparam int SA_MSB  = 7;
   localparam int SA_LSB  = 4;
   localparam int SB_MSB  = 3;
   localparam int SB_LSB  = 0;
   localparam int OFF_MSB = 7;

   function automatic logic [PC_W-1:0] sext_off(input logic signed [7:0] off);
      return PC_W'(off);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Next program-counter selection: hold, increment, relative branch or register jump, all modulo 2**PC_W.
module pc_next
   import instr_fetch_unit_pkg::*;
(
   input  logic [PC_W-1:0] pc,
   input  logic [1:0]      ps,
   input  logic [7:0]      br_off,
   input  logic [PC_W-1:0] jr_addr,
   output logic [PC_W-1:0] pc_nxt
);

   always_comb begin
      pc_nxt = pc;
      case (ps)
         PS_INC:  pc_nxt = pc + PC_W'(1);
         PS_BR:   pc_nxt = pc + sext_off(br_off);
         PS_JR:   pc_nxt = jr_addr;
         default: pc_nxt = pc;
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/execute sequencer: requests instructions at pc, latches them into IR and steps pc.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          PS,
   input  logic                IL,
   input  logic [PC_W-1:0]     jr_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                imem_ack,
   output logic                imem_req,
   output logic [PC_W-1:0]     imem_addr,
   output logic                state,
   output logic [3:0]          opcode,
   output logic [3:0]          dr,
   output logic [3:0]          sa,
   output logic [3:0]          sb,
   output logic [3:0]          eoe,
   output logic [PC_W-1:0]     pc,
   output logic [PC_W-1:0]     pc_link,
   output logic                halted
);

   fsm_e               fsm_q, fsm_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               halted_q, halted_d;
   logic [PC_W-1:0]    pc_nxt;

   pc_next u_pc_next (
      .pc      (pc_q),
      .ps      (PS),
      .br_off  (ir_q[OFF_MSB:0]),
      .jr_addr (jr_addr),
      .pc_nxt  (pc_nxt)
   );

   always_comb begin
      fsm_d    = fsm_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      halted_d = halted_q;
      case (fsm_q)
         FSM_FETCH: begin
            // An ack without IL leaves IR alone and simply re-requests
            if (imem_ack && IL) begin
               ir_d  = imem_rdata;
               fsm_d = FSM_EXEC;
            end
         end
         FSM_EXEC: begin
            if (PS == PS_HOLD) begin
               halted_d = 1'b1;
               fsm_d    = FSM_HALT;
            end else begin
               pc_d  = pc_nxt;
               fsm_d = FSM_FETCH;
            end
         end
         FSM_HALT: fsm_d = FSM_HALT;
         default:  fsm_d = FSM_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= FSM_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         halted_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         halted_q <= halted_d;
      end
   end

   // Gating with rst_n keeps the request low for the whole reset window
   assign imem_req  = rst_n && (fsm_q == FSM_FETCH);
   assign imem_addr = pc_q;
   assign state     = (fsm_q == FSM_EXEC);
   assign opcode    = ir_q[OPC_MSB:OPC_LSB];
   assign dr        = ir_q[DR_MSB:DR_LSB];
   assign sa        = ir_q[SA_MSB:SA_LSB];
   assign sb        = ir_q[SB_MSB:SB_LSB];
   assign eoe       = ir_q[SB_MSB:SB_LSB];
   assign pc        = pc_q;
   assign pc_link   = pc_q + PC_W'(1);
   assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scoreboard bench for instr_fetch_unit: EXEC-cycle observations are checked by a monitor.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [1:0]  PS;
   logic        IL;
   logic [7:0]  jr_addr;
   logic [15:0] imem_rdata;
   logic        imem_ack;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        state;
   logic [3:0]  opcode, dr, sa, sb, eoe;
   logic [7:0]  pc, pc_link;
   logic        halted;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] ir;
      logic [7:0]  pc;
      logic [7:0]  link;
   } exp_t;

   exp_t exp_q[$];

   instr_fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .PS         (PS),
      .IL         (IL),
      .jr_addr    (jr_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .state      (state),
      .opcode     (opcode),
      .dr         (dr),
      .sa         (sa),
      .sb         (sb),
      .eoe        (eoe),
      .pc         (pc),
      .pc_link    (pc_link),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [15:0] ir, input logic [7:0] p, input logic [7:0] l);
      exp_t e;
      e.ir   = ir;
      e.pc   = p;
      e.link = l;
      exp_q.push_back(e);
   endtask

   // Monitor: every EXEC cycle must match the next queued expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && state === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_exec: got pc %0h expected no EXEC", pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_ir", 32'({opcode, dr, sa, sb}), 32'(e.ir));
            chk("sb_eoe", 32'(eoe), 32'(e.ir[3:0]));
            chk("sb_pc", 32'(pc), 32'(e.pc));
            chk("sb_pc_link", 32'(pc_link), 32'(e.link));
            chk("sb_req_exec", 32'(imem_req), 0);
         end
      end
   end

   // Starts and ends at posedge+1; last cycle is the ack cycle, leaving the DUT in EXEC
   task automatic fetch(input logic [15:0] rd, input int waits, input logic [7:0] exp_pc);
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0;
         IL       = 1'b1;
         PS       = 2'b01;
         @(negedge clk);
         chk("req_wait", 32'(imem_req), 1);
         chk("addr_wait", 32'(imem_addr), 32'(exp_pc));
         chk("state_wait", 32'(state), 0);
         @(posedge clk); #1;
      end
      imem_ack   = 1'b1;
      IL         = 1'b1;
      imem_rdata = rd;
      PS         = 2'b01;
      @(negedge clk);
      chk("req_ack", 32'(imem_req), 1);
      chk("addr_ack", 32'(imem_addr), 32'(exp_pc));
      @(posedge clk); #1;
      imem_ack   = 1'b0;
      IL         = 1'b0;
      imem_rdata = 16'h0000;
   endtask

   task automatic exec(input logic [1:0] ps, input logic [7:0] jr, input logic [7:0] exp_next);
      PS      = ps;
      jr_addr = jr;
      @(negedge clk);
      @(posedge clk); #1;
      PS      = 2'b00;
      jr_addr = 8'h00;
      chk("pc_after_exec", 32'(pc), 32'(exp_next));
      chk("state_after_exec", 32'(state), 0);
      chk("halted_after_exec", 32'(halted), (ps == 2'b00) ? 1 : 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      PS         = 2'b00;
      IL         = 1'b0;
      jr_addr    = 8'h00;
      imem_rdata = 16'h0000;
      imem_ack   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", 32'(pc), 0);
      chk("rst_ir", 32'({opcode, dr, sa, sb}), 0);
      chk("rst_state", 32'(state), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_req", 32'(imem_req), 0);
      rst_n = 1'b1;
      #1;
      chk("req_after_release", 32'(imem_req), 1);

      // Zero-wait ack, then increment
      push_exp(16'h1234, 8'h00, 8'h01);
      fetch(16'h1234, 0, 8'h00);
      exec(2'b01, 8'h00, 8'h01);

      // Three wait cycles: request held four cycles at pc=01
      push_exp(16'h2003, 8'h01, 8'h02);
      fetch(16'h2003, 3, 8'h01);
      exec(2'b01, 8'h00, 8'h02);

      // Backward branch 0x02 + 0xFC = 0xFE
      push_exp(16'h30FC, 8'h02, 8'h03);
      fetch(16'h30FC, 1, 8'h02);
      exec(2'b10, 8'h00, 8'hFE);

      push_exp(16'h4000, 8'hFE, 8'hFF);
      fetch(16'h4000, 0, 8'hFE);
      exec(2'b01, 8'h00, 8'hFF);

      // Ack without IL: IR unchanged, stay in FETCH
      imem_ack   = 1'b1;
      IL         = 1'b0;
      imem_rdata = 16'hEEEE;
      @(negedge clk);
      chk("il0_req", 32'(imem_req), 1);
      @(posedge clk); #1;
      imem_ack = 1'b0;
      chk("il0_state", 32'(state), 0);
      chk("il0_ir", 32'({opcode, dr, sa, sb}), 32'h4000);
      chk("il0_req_again", 32'(imem_req), 1);

      // Wrap 0xFF + 1 = 0x00
      push_exp(16'h5111, 8'hFF, 8'h00);
      fetch(16'h5111, 0, 8'hFF);
      exec(2'b01, 8'h00, 8'h00);

      // Jump register
      push_exp(16'h6222, 8'h00, 8'h01);
      fetch(16'h6222, 0, 8'h00);
      exec(2'b11, 8'h5A, 8'h5A);

      // Halt with ack pulses injected
      push_exp(16'hF00F, 8'h5A, 8'h5B);
      fetch(16'hF00F, 1, 8'h5A);
      exec(2'b00, 8'h00, 8'h5A);
      for (int i = 0; i < 10; i++) begin
         imem_ack   = (i % 2 == 0);
         IL         = 1'b1;
         PS         = 2'b01;
         imem_rdata = 16'h1111;
         @(negedge clk);
         chk("halt_req", 32'(imem_req), 0);
         chk("halt_pc", 32'(pc), 32'h5A);
         chk("halt_halted", 32'(halted), 1);
         chk("halt_ir", 32'({opcode, dr, sa, sb}), 32'hF00F);
         chk("halt_eoe", 32'(eoe), 32'hF);
         chk("halt_state", 32'(state), 0);
         @(posedge clk); #1;
      end
      imem_ack = 1'b0;
      IL       = 1'b0;
      PS       = 2'b00;

      // Leave HALT, load an instruction so the next reset has something to clear
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_exp(16'h8456, 8'h00, 8'h01);
      fetch(16'h8456, 0, 8'h00);
      exec(2'b01, 8'h00, 8'h01);

      // Reset mid-fetch with ack arriving during reset
      imem_ack = 1'b0;
      @(negedge clk);
      chk("pre_rst_req", 32'(imem_req), 1);
      @(posedge clk); #1;
      rst_n      = 1'b0;
      imem_ack   = 1'b1;
      IL         = 1'b1;
      imem_rdata = 16'hABCD;
      @(negedge clk);
      chk("midrst_pc", 32'(pc), 0);
      chk("midrst_ir", 32'({opcode, dr, sa, sb}), 0);
      chk("midrst_req", 32'(imem_req), 0);
      chk("midrst_halted", 32'(halted), 0);
      @(posedge clk); #1;
      imem_ack = 1'b0;
      IL       = 1'b0;
      rst_n    = 1'b1;
      #1;
      chk("rel_req", 32'(imem_req), 1);
      chk("rel_addr", 32'(imem_addr), 0);
      chk("rel_ir", 32'({opcode, dr, sa, sb}), 0);
      @(posedge clk); #1;
      chk("rel_state", 32'(state), 0);
      chk("rel_ir_noload", 32'({opcode, dr, sa, sb}), 0);

      push_exp(16'h7123, 8'h00, 8'h01);
      fetch(16'h7123, 0, 8'h00);
      exec(2'b01, 8'h00, 8'h01);

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
